// File: rtl/mshr_queue.sv
// mshr_queue: in-order miss queue with load/store merging, a reserved
// writeback slot, tagged memory issue and head retirement with refill.
module mshr_queue #(
  parameter int DEPTH    = 8,
  parameter int LD_PORTS = 2,
  parameter int ST_PORTS = 3,
  parameter int XLEN     = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [LD_PORTS-1:0]           ld_req,
  input  logic [LD_PORTS-1:0][XLEN-1:0] ld_addr,
  output logic [LD_PORTS-1:0]           ld_ready,
  input  logic [ST_PORTS-1:0]           st_req,
  input  logic [ST_PORTS-1:0][XLEN-1:0] st_addr,
  input  logic [ST_PORTS-1:0][63:0]     st_data,
  input  logic [ST_PORTS-1:0][7:0]      st_bytes,
  output logic [ST_PORTS-1:0]           st_ready,
  input  logic                          wb_req,
  input  logic [XLEN-1:0]               wb_addr,
  input  logic [63:0]                   wb_data,
  output logic [LD_PORTS-1:0]           ld_hazard,
  output logic [1:0]                    mem_cmd,
  output logic [XLEN-1:0]               mem_addr,
  output logic [63:0]                   mem_data,
  input  logic [3:0]                    mem_response,
  input  logic [3:0]                    mem_tag,
  input  logic [63:0]                   mem_rdata,
  output logic                          refill_en,
  output logic [XLEN-1:0]               refill_addr,
  output logic [63:0]                   refill_data,
  output logic                          refill_dirty,
  output logic [LD_PORTS-1:0]           bc_valid,
  output logic [63:0]                   bc_data,
  output logic                          full,
  output logic                          empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = XLEN - 3;
  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam logic [PW:0] PONE  = (PW+1)'(1);
  localparam logic [PW:0] LIMIT = (PW+1)'(DEPTH-1);
  localparam logic [PW:0] FULLN = (PW+1)'(DEPTH);

  logic [DEPTH-1:0]    vld_q, vld_d, iss_q, iss_d, dty_q, dty_d;
  logic [1:0]          cmd_q  [DEPTH];
  logic [1:0]          cmd_d  [DEPTH];
  logic [LW-1:0]       line_q [DEPTH];
  logic [LW-1:0]       line_d [DEPTH];
  logic [63:0]         data_q [DEPTH];
  logic [63:0]         data_d [DEPTH];
  logic [7:0]          mask_q [DEPTH];
  logic [7:0]          mask_d [DEPTH];
  logic [3:0]          tag_q  [DEPTH];
  logic [3:0]          tag_d  [DEPTH];
  logic [LD_PORTS-1:0] wait_q [DEPTH];
  logic [LD_PORTS-1:0] wait_d [DEPTH];
  logic [PW:0]         head_q, head_d, issue_q, issue_d;
  logic [PW:0]         tail_q, tail_d, occ, cnt;
  logic [PW-1:0]       rh, ii, mi;
  logic [LW-1:0]       ln;
  logic                hit;
  logic                unused_lo;

  always_comb begin
    vld_d = vld_q; iss_d = iss_q; dty_d = dty_q;
    cmd_d = cmd_q; line_d = line_q; data_d = data_q;
    mask_d = mask_q; tag_d = tag_q; wait_d = wait_q;
    head_d = head_q; issue_d = issue_q; tail_d = tail_q;
    mem_cmd = BUS_NONE; mem_addr = '0; mem_data = '0;
    refill_en = 1'b0; refill_addr = '0; refill_data = '0;
    refill_dirty = 1'b0; bc_valid = '0;
    ld_ready = '0; st_ready = '0; ld_hazard = '0;
    rh = head_q[PW-1:0]; ii = issue_q[PW-1:0];
    cnt = tail_q - head_q; hit = 1'b0; mi = '0; ln = '0;

    for (int p = 0; p < LD_PORTS; p++)
      for (int e = 0; e < DEPTH; e++)
        if (vld_q[e] && cmd_q[e] == BUS_STORE &&
            line_q[e] == ld_addr[p][XLEN-1:3])
          ld_hazard[p] = 1'b1;

    if (issue_q != tail_q) begin
      mem_cmd  = cmd_q[ii];
      mem_addr = {line_q[ii], 3'b000};
      if (cmd_q[ii] == BUS_STORE) mem_data = data_q[ii];
      if (mem_response != 4'd0) begin
        iss_d[ii] = 1'b1;
        tag_d[ii] = mem_response;
        issue_d   = issue_q + PONE;
      end
    end

    // retiring entry is invalidated first so nothing can merge into it
    if (vld_q[rh] && iss_q[rh] &&
        (cmd_q[rh] == BUS_STORE || tag_q[rh] == mem_tag)) begin
      vld_d[rh] = 1'b0;
      iss_d[rh] = 1'b0;
      head_d    = head_q + PONE;
      if (cmd_q[rh] == BUS_LOAD) begin
        refill_en    = 1'b1;
        refill_addr  = {line_q[rh], 3'b000};
        refill_dirty = dty_q[rh];
        bc_valid     = wait_q[rh];
        for (int b = 0; b < 8; b++)
          refill_data[8*b +: 8] = mask_q[rh][b] ?
            data_q[rh][8*b +: 8] : mem_rdata[8*b +: 8];
      end
    end

    for (int p = LD_PORTS-1; p >= 0; p--) begin
      if (ld_req[p] && !ld_hazard[p]) begin
        ln = ld_addr[p][XLEN-1:3];
        hit = 1'b0;
        for (int e = 0; e < DEPTH; e++)
          if (!hit && vld_d[e] && cmd_d[e] == BUS_LOAD &&
              line_d[e] == ln) begin
            hit = 1'b1;
            mi  = PW'(e);
          end
        if (!hit && cnt < LIMIT) begin
          mi = tail_d[PW-1:0];
          vld_d[mi] = 1'b1; cmd_d[mi] = BUS_LOAD;
          line_d[mi] = ln; data_d[mi] = '0;
          mask_d[mi] = '0; dty_d[mi] = 1'b0;
          iss_d[mi] = 1'b0; tag_d[mi] = '0;
          wait_d[mi] = '0;
          tail_d = tail_d + PONE;
          cnt = cnt + PONE;
          hit = 1'b1;
        end
        if (hit) begin
          wait_d[mi][p] = 1'b1;
          ld_ready[p] = 1'b1;
        end
      end
    end

    for (int p = ST_PORTS-1; p >= 0; p--) begin
      if (st_req[p]) begin
        ln = st_addr[p][XLEN-1:3];
        hit = 1'b0;
        for (int e = 0; e < DEPTH; e++)
          if (!hit && vld_d[e] && cmd_d[e] == BUS_LOAD &&
              line_d[e] == ln) begin
            hit = 1'b1;
            mi  = PW'(e);
          end
        if (!hit && cnt < LIMIT) begin
          mi = tail_d[PW-1:0];
          vld_d[mi] = 1'b1; cmd_d[mi] = BUS_LOAD;
          line_d[mi] = ln; data_d[mi] = '0;
          mask_d[mi] = '0; dty_d[mi] = 1'b0;
          iss_d[mi] = 1'b0; tag_d[mi] = '0;
          wait_d[mi] = '0;
          tail_d = tail_d + PONE;
          cnt = cnt + PONE;
          hit = 1'b1;
        end
        if (hit) begin
          for (int b = 0; b < 8; b++)
            if (st_bytes[p][b])
              data_d[mi][8*b +: 8] = st_data[p][8*b +: 8];
          mask_d[mi] = mask_d[mi] | st_bytes[p];
          dty_d[mi] = 1'b1;
          st_ready[p] = 1'b1;
        end
      end
    end

    if (wb_req && cnt < FULLN) begin
      mi = tail_d[PW-1:0];
      vld_d[mi] = 1'b1; cmd_d[mi] = BUS_STORE;
      line_d[mi] = wb_addr[XLEN-1:3]; data_d[mi] = wb_data;
      mask_d[mi] = 8'hFF; dty_d[mi] = 1'b1;
      iss_d[mi] = 1'b0; tag_d[mi] = '0;
      wait_d[mi] = '0;
      tail_d = tail_d + PONE;
    end
  end

  always_comb begin
    unused_lo = ^wb_addr[2:0];
    for (int p = 0; p < LD_PORTS; p++)
      unused_lo = unused_lo ^ (^ld_addr[p][2:0]);
    for (int p = 0; p < ST_PORTS; p++)
      unused_lo = unused_lo ^ (^st_addr[p][2:0]);
  end

  assign occ     = tail_q - head_q;
  assign full    = occ == FULLN;
  assign empty   = occ == '0;
  assign bc_data = refill_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0; iss_q <= '0; dty_q <= '0;
      head_q <= '0; issue_q <= '0; tail_q <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        cmd_q[e] <= BUS_NONE; line_q[e] <= '0;
        data_q[e] <= '0; mask_q[e] <= '0;
        tag_q[e] <= '0; wait_q[e] <= '0;
      end
    end else begin
      vld_q <= vld_d; iss_q <= iss_d; dty_q <= dty_d;
      head_q <= head_d; issue_q <= issue_d; tail_q <= tail_d;
      cmd_q <= cmd_d; line_q <= line_d;
      data_q <= data_d; mask_q <= mask_d;
      tag_q <= tag_d; wait_q <= wait_d;
    end
  end
endmodule

// File: tb/tb_mshr_queue.sv
// tb_mshr_queue: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the miss queue.
module tb_mshr_queue;
  localparam int DEPTH = 8;
  localparam int LDP   = 2;
  localparam int STP   = 3;
  localparam int XLEN  = 32;

  logic clock = 1'b0;
  logic reset;
  logic [LDP-1:0]           ld_req, ld_ready, ld_hazard, bc_valid;
  logic [LDP-1:0][XLEN-1:0] ld_addr;
  logic [STP-1:0]           st_req, st_ready;
  logic [STP-1:0][XLEN-1:0] st_addr;
  logic [STP-1:0][63:0]     st_data;
  logic [STP-1:0][7:0]      st_bytes;
  logic                     wb_req;
  logic [XLEN-1:0]          wb_addr, mem_addr, refill_addr;
  logic [63:0]              wb_data, mem_data, mem_rdata;
  logic [63:0]              refill_data, bc_data;
  logic [1:0]               mem_cmd;
  logic [3:0]               mem_response, mem_tag;
  logic                     refill_en, refill_dirty, full, empty;

  mshr_queue #(
    .DEPTH(DEPTH), .LD_PORTS(LDP), .ST_PORTS(STP), .XLEN(XLEN)
  ) dut (
    .clock(clock), .reset(reset),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_ready(ld_ready),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data),
    .st_bytes(st_bytes), .st_ready(st_ready),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data),
    .ld_hazard(ld_hazard),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_response(mem_response), .mem_tag(mem_tag),
    .mem_rdata(mem_rdata),
    .refill_en(refill_en), .refill_addr(refill_addr),
    .refill_data(refill_data), .refill_dirty(refill_dirty),
    .bc_valid(bc_valid), .bc_data(bc_data),
    .full(full), .empty(empty)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]     cmd;
    logic [28:0]    line;
    logic [63:0]    data;
    logic [7:0]     mask;
    logic           dirty;
    logic           issued;
    logic [3:0]     tag;
    logic [LDP-1:0] waiters;
  } ent_t;

  ent_t q[$];
  int nvec = 0;
  int nmis = 0;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int find_load(ref ent_t qq[$], input logic [28:0] ln);
    for (int j = 0; j < qq.size(); j++)
      if (qq[j].cmd == 2'd1 && qq[j].line == ln) return j;
    return -1;
  endfunction

  task automatic model_step();
    ent_t nq[$];
    ent_t e;
    logic [LDP-1:0] x_haz, x_ldr, x_bc;
    logic [STP-1:0] x_str;
    logic [1:0]  x_cmd;
    logic [31:0] x_maddr, x_raddr;
    logic [63:0] x_mdata, x_rdata;
    logic x_ren, x_rdirty;
    int ii, cnt, j;
    bit ret;
    x_haz = '0; x_ldr = '0; x_bc = '0; x_str = '0;
    x_cmd = '0; x_maddr = '0; x_raddr = '0;
    x_mdata = '0; x_rdata = '0; x_ren = 0; x_rdirty = 0;
    for (int p = 0; p < LDP; p++)
      for (int k = 0; k < q.size(); k++)
        if (q[k].cmd == 2'd2 && q[k].line == ld_addr[p][31:3])
          x_haz[p] = 1'b1;
    ii = -1;
    for (int k = 0; k < q.size(); k++)
      if (ii < 0 && !q[k].issued) ii = k;
    if (ii >= 0) begin
      x_cmd = q[ii].cmd;
      x_maddr = {q[ii].line, 3'b000};
      if (q[ii].cmd == 2'd2) x_mdata = q[ii].data;
    end
    ret = q.size() > 0 && q[0].issued &&
          (q[0].cmd == 2'd2 || q[0].tag == mem_tag);
    if (ret && q[0].cmd == 2'd1) begin
      x_ren = 1; x_rdirty = q[0].dirty; x_bc = q[0].waiters;
      x_raddr = {q[0].line, 3'b000};
      for (int b = 0; b < 8; b++)
        x_rdata[8*b +: 8] = q[0].mask[b] ? q[0].data[8*b +: 8]
                                         : mem_rdata[8*b +: 8];
    end
    nq = q;
    cnt = q.size();
    if (ii >= 0 && mem_response != 0) begin
      nq[ii].issued = 1'b1;
      nq[ii].tag = mem_response;
    end
    if (ret) void'(nq.pop_front());
    for (int p = LDP-1; p >= 0; p--) begin
      if (ld_req[p] && !x_haz[p]) begin
        j = find_load(nq, ld_addr[p][31:3]);
        if (j < 0 && cnt < DEPTH-1) begin
          e = '0; e.cmd = 2'd1; e.line = ld_addr[p][31:3];
          nq.push_back(e); cnt++; j = nq.size() - 1;
        end
        if (j >= 0) begin
          e = nq[j]; e.waiters[p] = 1'b1; nq[j] = e;
          x_ldr[p] = 1'b1;
        end
      end
    end
    for (int p = STP-1; p >= 0; p--) begin
      if (st_req[p]) begin
        j = find_load(nq, st_addr[p][31:3]);
        if (j < 0 && cnt < DEPTH-1) begin
          e = '0; e.cmd = 2'd1; e.line = st_addr[p][31:3];
          nq.push_back(e); cnt++; j = nq.size() - 1;
        end
        if (j >= 0) begin
          e = nq[j];
          for (int b = 0; b < 8; b++)
            if (st_bytes[p][b]) e.data[8*b +: 8] = st_data[p][8*b +: 8];
          e.mask = e.mask | st_bytes[p];
          e.dirty = 1'b1;
          nq[j] = e;
          x_str[p] = 1'b1;
        end
      end
    end
    if (wb_req && cnt < DEPTH) begin
      e = '0; e.cmd = 2'd2; e.line = wb_addr[31:3];
      e.data = wb_data; e.mask = 8'hFF; e.dirty = 1'b1;
      nq.push_back(e);
    end
    check_eq("ld_hazard", ld_hazard, x_haz);
    check_eq("mem_cmd", mem_cmd, x_cmd);
    check_eq("mem_addr", mem_addr, x_maddr);
    check_eq("mem_data", mem_data, x_mdata);
    check_eq("refill_en", refill_en, x_ren);
    check_eq("refill_addr", refill_addr, x_raddr);
    check_eq("refill_data", refill_data, x_rdata);
    check_eq("refill_dirty", refill_dirty, x_rdirty);
    check_eq("bc_valid", bc_valid, x_bc);
    check_eq("bc_data", bc_data, x_rdata);
    check_eq("ld_ready", ld_ready, x_ldr);
    check_eq("st_ready", st_ready, x_str);
    check_eq("full", full, q.size() == DEPTH);
    check_eq("empty", empty, q.size() == 0);
    if (reset) q.delete();
    else q = nq;
  endtask

  task automatic tick();
    #1;
    model_step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    reset = 0; ld_req = '0; ld_addr = '0;
    st_req = '0; st_addr = '0; st_data = '0; st_bytes = '0;
    wb_req = 0; wb_addr = '0; wb_data = '0;
    mem_response = '0; mem_tag = '0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  function automatic logic [28:0] pick_line();
    return 29'h20 + 29'($urandom_range(0, 7));
  endfunction

  task automatic drive_random(input int rate);
    for (int p = 0; p < LDP; p++) begin
      ld_req[p] = $urandom_range(0, 99) < rate;
      ld_addr[p] = {pick_line(), 1'($urandom_range(0, 1)), 2'b00};
    end
    for (int p = 0; p < STP; p++) begin
      st_req[p] = $urandom_range(0, 99) < rate / 2;
      st_addr[p] = {pick_line(), 3'b000};
      st_data[p] = {$urandom, $urandom};
      st_bytes[p] = 8'($urandom);
    end
    wb_req = $urandom_range(0, 99) < rate / 4;
    wb_addr = {pick_line(), 3'b000};
    wb_data = {$urandom, $urandom};
    mem_response = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'd0;
    if (q.size() > 0 && q[0].issued && $urandom_range(0, 1))
      mem_tag = q[0].tag;
    else
      mem_tag = 4'($urandom_range(0, 15));
    mem_rdata = {$urandom, $urandom};
    reset = $urandom_range(0, 299) == 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 0;
    q.delete();
    #1;
    check_eq("rst_empty", empty, 1'b1);
    check_eq("rst_full", full, 1'b0);
    check_eq("rst_mem_cmd", mem_cmd, 2'd0);
    check_eq("rst_refill_en", refill_en, 1'b0);
    check_eq("rst_bc_valid", bc_valid, 2'b00);

    // two load misses, port 1 issued first
    clear_inputs();
    ld_req = 2'b11; ld_addr[1] = 32'h100; ld_addr[0] = 32'h200;
    tick();
    clear_inputs(); mem_response = 4'd1;
    #1 check_eq("two_ld_issue1", mem_addr, 32'h100);
    tick();
    clear_inputs(); mem_response = 4'd2;
    #1 check_eq("two_ld_issue2", mem_addr, 32'h200);
    tick();
    clear_inputs(); mem_tag = 4'd1;
    #1 check_eq("two_ld_refill1", refill_addr, 32'h100);
    tick();
    clear_inputs(); mem_tag = 4'd2;
    #1 check_eq("two_ld_refill2", refill_addr, 32'h200);
    tick();

    // same-line loads share one entry
    do_reset();
    ld_req = 2'b11; ld_addr[1] = 32'h140; ld_addr[0] = 32'h144;
    #1 check_eq("merge_ready", ld_ready, 2'b11);
    tick();
    clear_inputs(); mem_response = 4'd1;
    tick();
    clear_inputs(); mem_tag = 4'd1;
    #1 check_eq("merge_bc", bc_valid, 2'b11);
    tick();
    clear_inputs();
    #1 check_eq("merge_empty", empty, 1'b1);
    tick();

    // store miss refill merges store bytes
    do_reset();
    st_req = 3'b001; st_addr[0] = 32'h300;
    st_data[0] = 64'h11223344; st_bytes[0] = 8'h0F;
    tick();
    clear_inputs(); mem_response = 4'd3;
    #1 check_eq("st_issue_cmd", mem_cmd, 2'd1);
    tick();
    clear_inputs(); mem_tag = 4'd3; mem_rdata = '1;
    #1 check_eq("st_refill_data", refill_data, 64'hFFFFFFFF11223344);
    check_eq("st_refill_dirty", refill_dirty, 1'b1);
    tick();

    // reserved writeback slot
    do_reset();
    for (int i = 0; i < DEPTH-1; i++) begin
      clear_inputs();
      ld_req = 2'b01; ld_addr[0] = 32'h400 + 32'(i * 8);
      tick();
    end
    clear_inputs();
    ld_req = 2'b01; ld_addr[0] = 32'h600;
    st_req = 3'b001; st_addr[0] = 32'h608; st_bytes[0] = 8'h01;
    wb_req = 1; wb_addr = 32'h700; wb_data = 64'hA5;
    #1 check_eq("cap_ld_ready", ld_ready, 2'b00);
    check_eq("cap_st_ready", st_ready, 3'b000);
    tick();
    clear_inputs();
    #1 check_eq("cap_full", full, 1'b1);
    tick();

    // rejected issue held, then accepted with tag 5
    do_reset();
    ld_req = 2'b01; ld_addr[0] = 32'h500;
    tick();
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      #1 check_eq("hold_cmd", mem_cmd, 2'd1);
      tick();
    end
    clear_inputs(); mem_response = 4'd5;
    tick();
    clear_inputs(); mem_tag = 4'd5;
    #1 check_eq("hold_retire", refill_addr, 32'h500);
    tick();

    for (int i = 0; i < 1000; i++) begin drive_random(60); tick(); end
    for (int i = 0; i < 1000; i++) begin drive_random(20); tick(); end
    for (int i = 0; i < 300; i++) begin drive_random(0); tick(); end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
